// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
package io_cond_pkg;

  localparam int unsigned IO_COND_NUM_INPUTS      = 10;
  localparam int unsigned IO_COND_SYNC_STAGES     = 2;
  localparam int unsigned IO_COND_DEBOUNCE_CYCLES = 4;

  // Debounce counter width: clog2(cycles)+1 so the terminal count always fits.
  function automatic int unsigned cnt_width(input int cycles);
    return int'($clog2(cycles)) + 1;
  endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// Event drain handshake between the conditioner (master) and the core (slave).
//   evt_valid : pending event flags non-zero
//   evt_ready : consumer accepts evt_data
//   evt_data  : sticky per-bit "changed since last accept" flags
interface io_input_conditioner_if #(
  parameter int unsigned NUM_INPUTS = 10
);
  logic                  evt_valid;
  logic                  evt_ready;
  logic [NUM_INPUTS-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/io_cond_bit.sv
// One conditioned input bit: synchronizer chain, debounce filter, edge detect.
//   clk, rst  : clock, synchronous active-high reset
//   in_raw    : asynchronous pad input
//   in_clean  : synchronized, debounced level
//   rise/fall : one-cycle pulses coincident with in_clean changing
module io_cond_bit
  import io_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic in_clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(int'(DEBOUNCE_CYCLES));
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  // MSB of the chain is the last (most settled) stage.
  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_raw};
    clean_d = clean_q;
    cnt_d   = cnt_q;
    // Any cycle agreeing with the accepted level restarts the filter.
    if (sync == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Edge pulses are registered alongside clean so they line up with in_clean.
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign in_clean = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Pad input conditioner: per-bit sync/debounce/edge detect plus a sticky
// event register drained by the core over a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   in_raw    : asynchronous pad inputs
//   in_clean  : conditioned levels
//   rise/fall : per-bit edge pulses
//   evt       : event handshake (master side)
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned NUM_INPUTS      = IO_COND_NUM_INPUTS,
  parameter int unsigned SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = IO_COND_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] in_raw,
  output logic [NUM_INPUTS-1:0] in_clean,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall,
  io_input_conditioner_if.master evt
);

  logic [NUM_INPUTS-1:0] pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic [NUM_INPUTS-1:0] edges;
  logic                  accept;

  // Per-bit conditioning.
  for (genvar i = 0; i < int'(NUM_INPUTS); i++) begin : g_bit
    io_cond_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .in_raw  (in_raw[i]),
      .in_clean(in_clean[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign edges  = rise | fall;
  assign accept = valid_q & evt.evt_ready;

  // On accept the register reloads with this cycle's edges so none is lost.
  always_comb begin
    pend_d  = pend_q | edges;
    if (accept) begin
      pend_d = edges;
    end
    valid_d = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  assign evt.evt_data  = pend_q;
  assign evt.evt_valid = valid_q;

endmodule
